// File: rtl/vx_div_sched_pkg.sv
// Shared definitions for the divider scheduler: FSM encodings and the
// requester-index width helper.
package vx_div_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RSP   = 2'd3;

  typedef logic [1:0] state_t;

  // Index width that stays at least one bit wide for a single requester.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_REQS = 4;
  localparam int REQ_SEL_BITS = sel_bits(DEF_NUM_REQS);

endpackage

// File: rtl/vx_div_sched_if.sv
// Bundle of requester, response and divider-side signals of the scheduler.
// slave = scheduler view, master = requesters plus divider view.
interface vx_div_sched_if #(
  parameter int NUM_REQS  = 4,
  parameter int LANES     = 1,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
);
  import vx_div_sched_pkg::*;

  localparam int SEL = sel_bits(NUM_REQS);
  localparam int DW  = LANES * WIDTH;

  logic [NUM_REQS-1:0]                req_valid;
  logic [NUM_REQS-1:0]                req_ready;
  logic [NUM_REQS-1:0]                req_is_signed;
  logic [NUM_REQS-1:0]                req_is_rem;
  logic [NUM_REQS-1:0][DW-1:0]        req_numer;
  logic [NUM_REQS-1:0][DW-1:0]        req_denom;
  logic [NUM_REQS-1:0][TAG_WIDTH-1:0] req_tag;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DW-1:0]        rsp_data;
  logic [TAG_WIDTH-1:0] rsp_tag;
  logic [SEL-1:0]       rsp_idx;

  logic          div_strobe;
  logic          div_busy;
  logic          div_is_signed;
  logic [DW-1:0] div_numer;
  logic [DW-1:0] div_denom;
  logic [DW-1:0] div_quotient;
  logic [DW-1:0] div_remainder;

  modport slave (
    input  req_valid, req_is_signed, req_is_rem, req_numer, req_denom, req_tag,
    output req_ready,
    output rsp_valid, rsp_data, rsp_tag, rsp_idx,
    input  rsp_ready,
    output div_strobe, div_is_signed, div_numer, div_denom,
    input  div_busy, div_quotient, div_remainder
  );

  modport master (
    output req_valid, req_is_signed, req_is_rem, req_numer, req_denom, req_tag,
    input  req_ready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_idx,
    output rsp_ready,
    input  div_strobe, div_is_signed, div_numer, div_denom,
    output div_busy, div_quotient, div_remainder
  );

endinterface

// File: rtl/vx_div_rr_arbiter.sv
// Round-robin arbiter: grants the first valid at or after the pointer and
// moves the pointer past the winner only when en_i reports the grant was used.
module vx_div_rr_arbiter
  import vx_div_sched_pkg::*;
#(
  parameter int N = 4,
  localparam int SEL = sel_bits(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   valid_i,
  input  logic           en_i,
  output logic [N-1:0]   grant_o,
  output logic [SEL-1:0] grant_idx_o
);

  logic [SEL-1:0] ptr_q, ptr_d;
  logic [31:0]    j;
  logic           found;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = '0;
    for (int i = 0; i < N; i++) begin
      j = 32'(ptr_q) + 32'(i);
      if (j >= 32'(N)) j = j - 32'(N);
      if (!found && valid_i[j[SEL-1:0]]) begin
        found                 = 1'b1;
        grant_o[j[SEL-1:0]]   = 1'b1;
        grant_idx_o           = j[SEL-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = (grant_idx_o == SEL'(N - 1)) ? '0 : grant_idx_o + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/vx_div_sched.sv
// Time-shares one external serial divider among NUM_REQS requesters:
// arbitrate, latch operands, strobe, wait out busy, return tagged result.
module vx_div_sched
  import vx_div_sched_pkg::*;
#(
  parameter int NUM_REQS  = 4,
  parameter int LANES     = 1,
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  vx_div_sched_if.slave  bus
);

  localparam int SEL = sel_bits(NUM_REQS);
  localparam int DW  = LANES * WIDTH;

  state_t state_q, state_d;

  logic [NUM_REQS-1:0] gnt;
  logic [SEL-1:0]      gnt_idx;
  logic                idle;
  logic                fire;
  logic                capture;

  logic [DW-1:0]        numer_q, denom_q;
  logic                 signed_q, rem_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic [SEL-1:0]       idx_q;

  logic [DW-1:0]        rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q;
  logic [SEL-1:0]       rsp_idx_q;

  // Grants exist only for valid requesters, so any grant in IDLE is a fire.
  assign idle    = (state_q == ST_IDLE) && !reset;
  assign fire    = idle && (|gnt);
  assign capture = (state_q == ST_WAIT) && !bus.div_busy;

  vx_div_rr_arbiter #(.N(NUM_REQS)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (bus.req_valid),
    .en_i        (fire),
    .grant_o     (gnt),
    .grant_idx_o (gnt_idx)
  );

  assign bus.req_ready = idle ? gnt : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fire) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (!bus.div_busy) state_d = ST_RSP;
      ST_RSP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Operand context: only written on a fire, so it is frozen for ISSUE..RSP.
  always_ff @(posedge clk) begin
    if (fire) begin
      numer_q  <= bus.req_numer[gnt_idx];
      denom_q  <= bus.req_denom[gnt_idx];
      signed_q <= bus.req_is_signed[gnt_idx];
      rem_q    <= bus.req_is_rem[gnt_idx];
      tag_q    <= bus.req_tag[gnt_idx];
      idx_q    <= gnt_idx;
    end
  end

  genvar l;
  generate
    for (l = 0; l < LANES; l++) begin : g_lane
      assign rsp_data_d[l*WIDTH +: WIDTH] = rem_q ? bus.div_remainder[l*WIDTH +: WIDTH]
                                                  : bus.div_quotient[l*WIDTH +: WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_idx_q  <= '0;
    end else if (capture) begin
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= tag_q;
      rsp_idx_q  <= idx_q;
    end
  end

  assign bus.rsp_valid     = (state_q == ST_RSP);
  assign bus.rsp_data      = rsp_data_q;
  assign bus.rsp_tag       = rsp_tag_q;
  assign bus.rsp_idx       = rsp_idx_q;

  assign bus.div_strobe    = (state_q == ST_ISSUE);
  assign bus.div_is_signed = signed_q;
  assign bus.div_numer     = numer_q;
  assign bus.div_denom     = denom_q;

endmodule

// File: tb/tb_vx_div_sched.sv
// Bench for vx_div_sched with a behavioural RISC-V serial divider and a
// response scoreboard.
module tb_vx_div_sched;
  import vx_div_sched_pkg::*;

  localparam int NR = 4;
  localparam int L  = 1;
  localparam int W  = 32;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vx_div_sched_if #(.NUM_REQS(NR), .LANES(L), .WIDTH(W), .TAG_WIDTH(TW)) bus ();

  vx_div_sched #(.NUM_REQS(NR), .LANES(L), .WIDTH(W), .TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  tag;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fires    = 0;
  int fire_cyc = 0;
  logic [NR-1:0] prev_rdy = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rv_div(input logic s, input logic [31:0] n, input logic [31:0] d);
    logic [31:0] q, r;
    if (d == 0) begin
      q = '1; r = n;
    end else if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n; r = '0;
    end else if (s) begin
      q = $signed(n) / $signed(d);
      r = $signed(n) % $signed(d);
    end else begin
      q = n / d;
      r = n % d;
    end
    return {q, r};
  endfunction

  // Divider model: busy the cycle after strobe, for W cycles.
  int unsigned dcnt = 0;
  logic [31:0] dq = '0, dr = '0;
  always @(posedge clk) begin
    if (reset) dcnt <= 0;
    else if (bus.div_strobe) begin
      dcnt <= W;
      {dq, dr} <= rv_div(bus.div_is_signed, bus.div_numer, bus.div_denom);
    end else if (dcnt != 0) dcnt <= dcnt - 1;
  end
  assign bus.div_busy      = (dcnt != 0);
  assign bus.div_quotient  = dq;
  assign bus.div_remainder = dr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
        chk("rsp_tag",  64'(bus.rsp_tag),  64'(mon_e.tag));
        chk("rsp_idx",  64'(bus.rsp_idx),  64'(mon_e.idx));
      end
    end
  end

  always @(negedge clk) begin
    if (|bus.req_ready) begin
      chk("rdy_pulse",  64'(prev_rdy & bus.req_ready), 64'd0);
      chk("rdy_onehot", 64'($onehot(bus.req_ready)), 64'd1);
    end
    if (!reset) fires <= fires + $countones(bus.req_valid & bus.req_ready);
    prev_rdy <= bus.req_ready;
  end

  task automatic do_req(input int i, input logic s, input logic rem, input logic [31:0] n,
                        input logic [31:0] d, input logic [7:0] tag, input logic [31:0] exp,
                        input logic push);
    logic got;
    @(posedge clk); #1;
    bus.req_is_signed[i] = s;
    bus.req_is_rem[i]    = rem;
    bus.req_numer[i]     = n;
    bus.req_denom[i]     = d;
    bus.req_tag[i]       = tag;
    bus.req_valid[i]     = 1'b1;
    if (push) sb.push_back('{exp, tag, 2'(i)});
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) begin
        got = 1'b1;
        fire_cyc = cyc;
      end
    end
    if (!got) chk("fire_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp_lat(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        got = 1'b1;
        chk(name, 64'(cyc - fire_cyc), 64'(W + 3));
      end
    end
    if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rsp_valid) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic got;
    bus.req_valid     = '1;
    bus.req_is_signed = '0;
    bus.req_is_rem    = '0;
    bus.req_numer     = '0;
    bus.req_denom     = '0;
    bus.req_tag       = '0;
    bus.rsp_ready     = 1'b1;
    reset             = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_strobe",    64'(bus.div_strobe), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset         = 1'b0;
    @(negedge clk);
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("rst_rsp_tag",  64'(bus.rsp_tag),  64'd0);
    chk("rst_rsp_idx",  64'(bus.rsp_idx),  64'd0);

    // Round-robin among 0, 1, 3 held valid: 100/(i+1) each.
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      bus.req_numer[i] = 32'd100;
      bus.req_denom[i] = 32'(i + 1);
      bus.req_tag[i]   = 8'hA0 + 8'(i);
    end
    sb.push_back('{32'd100, 8'hA0, 2'd0});
    sb.push_back('{32'd50,  8'hA1, 2'd1});
    sb.push_back('{32'd25,  8'hA3, 2'd3});
    sb.push_back('{32'd100, 8'hA0, 2'd0});
    bus.req_valid = 4'b1011;
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(posedge clk);
      if (fires >= 4) got = 1'b1;
    end
    #1 bus.req_valid = '0;
    chk("arb_fires", 64'(got), 64'd1);
    drain();

    do_req(0, 1'b0, 1'b0, 32'd100, 32'd7, 8'h11, 32'd14, 1'b1);
    wait_rsp_lat("lat_quo");
    drain();
    do_req(0, 1'b0, 1'b1, 32'd100, 32'd7, 8'h11, 32'd2, 1'b1);
    wait_rsp_lat("lat_rem");
    drain();

    do_req(2, 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 8'h21, 32'hFFFF_FFFD, 1'b1); drain();
    do_req(2, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 8'h22, 32'hFFFF_FFFF, 1'b1); drain();
    do_req(1, 1'b0, 1'b0, 32'd5,         32'd0, 8'h31, 32'hFFFF_FFFF, 1'b1); drain();
    do_req(1, 1'b0, 1'b1, 32'd5,         32'd0, 8'h32, 32'd5,         1'b1); drain();
    do_req(3, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd0, 8'h33, 32'hFFFF_FFFF, 1'b1); drain();
    do_req(3, 1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 8'h34, 32'hFFFF_FFFB, 1'b1); drain();
    do_req(0, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h41, 32'h8000_0000, 1'b1); drain();
    do_req(0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h42, 32'd0, 1'b1); drain();

    // Backpressure with a second request waiting on requester 1.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    do_req(2, 1'b0, 1'b0, 32'd1000, 32'd10, 8'h55, 32'd100, 1'b1);
    bus.req_is_signed[1] = 1'b0;
    bus.req_is_rem[1]    = 1'b0;
    bus.req_numer[1]     = 32'd81;
    bus.req_denom[1]     = 32'd9;
    bus.req_tag[1]       = 8'h66;
    bus.req_valid[1]     = 1'b1;
    sb.push_back('{32'd9, 8'h66, 2'd1});
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    chk("bp_rsp_seen", 64'(got), 64'd1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_hold", {16'd0, bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_idx,
                      bus.req_ready, bus.div_strobe},
                     {16'd0, 1'b1, 32'd100, 8'h55, 2'd2, 4'b0000, 1'b0});
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_next_accept", 64'(bus.req_ready), 64'b0010);
    @(posedge clk); #1 bus.req_valid[1] = 1'b0;
    drain();

    // Reset in the 10th busy cycle discards the in-flight op.
    do_req(2, 1'b0, 1'b0, 32'd77, 32'd7, 8'h77, 32'd11, 1'b0);
    n = 0;
    for (int k = 0; k < 100 && n < 9; k++) begin
      @(negedge clk);
      if (bus.div_busy) n++;
    end
    chk("rst_busy_reached", 64'(n), 64'd9);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_strobe",    64'(bus.div_strobe), 64'd0);
    do_req(2, 1'b0, 1'b0, 32'd81, 32'd9, 8'h99, 32'd9, 1'b1);
    wait_rsp_lat("lat_after_rst");
    drain();
    repeat (40) @(negedge clk);
    chk("post_rst_quiet", 64'(bus.rsp_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
